// File: rtl/mod12_hour_tracker_if.sv
// -----------------------------------------------------------------------------
// mod12_hour_tracker_if
//
// Purpose:
//   This interface bundles the data path between the upstream mod-12 counter,
//   the hour tracker and the display/annunciator stage.
//
// Signals:
//   c_in      4       count from the upstream mod-12 counter
//   load_in   1       upstream load strobe (same cycle as the counter's load)
//   err_clr   1       clears the sticky error flag
//   hr_tens   4       BCD tens digit of the displayed hour (0 or 1)
//   hr_units  4       BCD units digit of the displayed hour
//   pm        1       AM(0)/PM(1) indicator
//   upd       1       one-cycle pulse when the displayed hour or pm changed
//   err       1       sticky error flag
//   wrap_cnt  WRAP_W  number of 11->0 wraps since reset
//
// Modports:
//   master  the driving side (upstream counter plus display consumer)
//   slave   the hour tracker itself
// -----------------------------------------------------------------------------
interface mod12_hour_tracker_if #(
  parameter int WRAP_W = 8
);
  logic [3:0]        c_in;
  logic              load_in;
  logic              err_clr;
  logic [3:0]        hr_tens;
  logic [3:0]        hr_units;
  logic              pm;
  logic              upd;
  logic              err;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output c_in,
    output load_in,
    output err_clr,
    input  hr_tens,
    input  hr_units,
    input  pm,
    input  upd,
    input  err,
    input  wrap_cnt
  );

  modport slave (
    input  c_in,
    input  load_in,
    input  err_clr,
    output hr_tens,
    output hr_units,
    output pm,
    output upd,
    output err,
    output wrap_cnt
  );
endinterface

// File: rtl/mod12_hour_tracker.sv
// -----------------------------------------------------------------------------
// mod12_hour_tracker
//
// Purpose:
//   This block sits downstream of a loadable mod-12 up counter. It converts
//   the count to a 12-hour BCD display, where count 0 is shown as hour 12.
//   It toggles AM/PM on every 11->0 wrap and counts those wraps. It also
//   raises a sticky error on illegal counts (12..15) and on jumps that no
//   load explains.
//
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  asynchronous, active-high reset
//   bus   slave modport of mod12_hour_tracker_if:
//           in : c_in[3:0], load_in, err_clr
//           out: hr_tens[3:0], hr_units[3:0], pm, upd, err,
//                wrap_cnt[WRAP_W-1:0]
//
// Parameters:
//   WRAP_W    width of wrap_cnt
//   WRAP_SAT  1: wrap_cnt saturates at all-ones, 0: wrap_cnt rolls over
//   START_PM  pm value after reset
//
// All outputs are registered. A sample of c_in shows up on the outputs one
// clock later.
// -----------------------------------------------------------------------------
module mod12_hour_tracker #(
  parameter int WRAP_W   = 8,
  parameter bit WRAP_SAT = 1'b1,
  parameter bit START_PM = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  mod12_hour_tracker_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [3:0] MAX_COUNT = 4'd11;

  // State registers.
  state_t            state_q,    state_d;
  logic [3:0]        prev_q,     prev_d;
  logic              load_d_q;                // load_in delayed one clock
  logic [3:0]        hr_tens_q,  hr_tens_d;
  logic [3:0]        hr_units_q, hr_units_d;
  logic              pm_q,       pm_d;
  logic              upd_q,      upd_d;
  logic              err_q,      err_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Decode helpers.
  logic       c_legal;
  logic [3:0] prev_plus1;
  logic       show;        // accept c_in as the new displayed hour
  logic       new_err;     // an error condition was detected this cycle
  logic       wrap_hit;    // legal 11->0 wrap detected this cycle
  logic [7:0] bcd_c;

  // Map a count to the {tens, units} BCD of the 12-hour display.
  // A count of 0 is displayed as 12. Illegal counts never reach the display,
  // so the default arm only exists to keep the function total.
  function automatic logic [7:0] count_to_bcd(input logic [3:0] c);
    logic [7:0] r;
    case (c)
      4'd0:    r = {4'd1, 4'd2};
      4'd10:   r = {4'd1, 4'd0};
      4'd11:   r = {4'd1, 4'd1};
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9:
               r = {4'd0, c};
      default: r = {4'd1, 4'd2};
    endcase
    return r;
  endfunction

  assign c_legal    = (bus.c_in <= MAX_COUNT);
  assign prev_plus1 = prev_q + 4'd1;
  assign bcd_c      = count_to_bcd(bus.c_in);

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    hr_tens_d  = hr_tens_q;
    hr_units_d = hr_units_q;
    pm_d       = pm_q;
    wrap_cnt_d = wrap_cnt_q;
    upd_d      = 1'b0;
    show       = 1'b0;
    new_err    = 1'b0;
    wrap_hit   = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        // First edge after reset: there is no history yet, so take the
        // count as it is.
        prev_d = bus.c_in;
        if (c_legal) begin
          show    = 1'b1;
          state_d = ST_TRACK;
        end else begin
          new_err = 1'b1;
          state_d = ST_FAULT;
        end
      end

      ST_TRACK: begin
        // The first match wins. The wrap test comes before the load test,
        // so a load from 11 to 0 still counts as a wrap.
        if (!c_legal) begin
          new_err = 1'b1;
          state_d = ST_FAULT;
        end else if (bus.c_in == prev_q) begin
          // No change, so hold.
        end else if ((prev_q == MAX_COUNT) && (bus.c_in == 4'd0)) begin
          wrap_hit = 1'b1;
          show     = 1'b1;
        end else if (bus.c_in == prev_plus1) begin
          show = 1'b1;
        end else if (load_d_q) begin
          // This jump follows a load. It is legal but is not a wrap.
          show = 1'b1;
        end else begin
          // This jump has no load behind it. Display the count but flag it.
          show    = 1'b1;
          new_err = 1'b1;
        end
      end

      ST_FAULT: begin
        // Recover on the first legal count. The FSM does not compare against
        // the value before the fault, so re-entry is never a wrap.
        if (c_legal) begin
          show    = 1'b1;
          state_d = ST_TRACK;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (show) begin
      prev_d     = bus.c_in;
      hr_tens_d  = bcd_c[7:4];
      hr_units_d = bcd_c[3:0];
      upd_d      = 1'b1;
    end

    if (wrap_hit) begin
      pm_d = ~pm_q;
      if (!(WRAP_SAT && (&wrap_cnt_q))) begin
        wrap_cnt_d = wrap_cnt_q + {{(WRAP_W-1){1'b0}}, 1'b1};
      end
    end

    // The error is sticky. A new error in the same cycle overrides err_clr.
    err_d = new_err | (err_q & ~bus.err_clr);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      prev_q     <= 4'd0;
      load_d_q   <= 1'b0;
      hr_tens_q  <= 4'd1;
      hr_units_q <= 4'd2;
      pm_q       <= START_PM;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      load_d_q   <= bus.load_in;
      hr_tens_q  <= hr_tens_d;
      hr_units_q <= hr_units_d;
      pm_q       <= pm_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign bus.hr_tens  = hr_tens_q;
  assign bus.hr_units = hr_units_q;
  assign bus.pm       = pm_q;
  assign bus.upd      = upd_q;
  assign bus.err      = err_q;
  assign bus.wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_mod12_hour_tracker.sv
// Bench for mod12_hour_tracker. It drives three instances from the same
// stimulus:
//   - the default build (8-bit saturating wrap counter)
//   - a 2-bit saturating build
//   - a 2-bit rolling build
// The bench pushes its expectations onto a scoreboard queue when it drives a
// sample. It pops and compares them one clock later.
module tb_mod12_hour_tracker;

  logic clk;
  logic rst;
  logic [3:0] c_in_tb;
  logic load_tb;
  logic clr_tb;

  int checks;
  int failures;

  // Expected pm and total number of wraps since the last reset.
  logic exp_pm;
  int   exp_wraps;

  typedef struct {
    string tag;
    int    hour;
    logic  pm;
    logic  upd;
    logic  err;
    int    wraps;
  } exp_t;

  exp_t sb_q[$];

  mod12_hour_tracker_if #(.WRAP_W(8)) if_main ();
  mod12_hour_tracker_if #(.WRAP_W(2)) if_sat  ();
  mod12_hour_tracker_if #(.WRAP_W(2)) if_roll ();

  assign if_main.c_in    = c_in_tb;
  assign if_main.load_in = load_tb;
  assign if_main.err_clr = clr_tb;
  assign if_sat.c_in     = c_in_tb;
  assign if_sat.load_in  = load_tb;
  assign if_sat.err_clr  = clr_tb;
  assign if_roll.c_in    = c_in_tb;
  assign if_roll.load_in = load_tb;
  assign if_roll.err_clr = clr_tb;

  mod12_hour_tracker #(.WRAP_W(8), .WRAP_SAT(1'b1), .START_PM(1'b0)) dut_main (
    .clk (clk),
    .rst (rst),
    .bus (if_main.slave)
  );

  mod12_hour_tracker #(.WRAP_W(2), .WRAP_SAT(1'b1), .START_PM(1'b0)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (if_sat.slave)
  );

  mod12_hour_tracker #(.WRAP_W(2), .WRAP_SAT(1'b0), .START_PM(1'b0)) dut_roll (
    .clk (clk),
    .rst (rst),
    .bus (if_roll.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Compare every output of all three instances with one scoreboard entry.
  task automatic compare_out();
    exp_t e;
    int   sat_w;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, ".tens"},  int'(if_main.hr_tens),  e.hour / 10);
    check({e.tag, ".units"}, int'(if_main.hr_units), e.hour % 10);
    check({e.tag, ".pm"},    int'(if_main.pm),       int'(e.pm));
    check({e.tag, ".upd"},   int'(if_main.upd),      int'(e.upd));
    check({e.tag, ".err"},   int'(if_main.err),      int'(e.err));
    check({e.tag, ".wrap8"}, int'(if_main.wrap_cnt), (e.wraps > 255) ? 255 : e.wraps);
    sat_w = (e.wraps > 3) ? 3 : e.wraps;
    check({e.tag, ".wrap_sat"},  int'(if_sat.wrap_cnt),  sat_w);
    check({e.tag, ".wrap_roll"}, int'(if_roll.wrap_cnt), e.wraps % 4);
    check({e.tag, ".pm_sat"},    int'(if_sat.pm),        int'(e.pm));
    check({e.tag, ".err_roll"},  int'(if_roll.err),      int'(e.err));
  endtask

  // Present one sample at the falling edge. Record what the outputs must show
  // after the next rising edge, then check them just after that edge.
  task automatic drive(input string tag, input logic [3:0] c, input logic ld,
                       input logic clr, input int hour, input logic upd_e,
                       input logic err_e);
    exp_t e;
    @(negedge clk);
    c_in_tb = c;
    load_tb = ld;
    clr_tb  = clr;
    e.tag   = $sformatf("%s(c=%0d)", tag, c);
    e.hour  = hour;
    e.pm    = exp_pm;
    e.upd   = upd_e;
    e.err   = err_e;
    e.wraps = exp_wraps;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
    $display("txn %s c=%0d ld=%0b clr=%0b -> hr=%0d%0d pm=%0b upd=%0b err=%0b wrap=%0d",
             tag, c, ld, clr, if_main.hr_tens, if_main.hr_units, if_main.pm,
             if_main.upd, if_main.err, if_main.wrap_cnt);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".tens"},  int'(if_main.hr_tens),  1);
    check({tag, ".units"}, int'(if_main.hr_units), 2);
    check({tag, ".pm"},    int'(if_main.pm),       0);
    check({tag, ".upd"},   int'(if_main.upd),      0);
    check({tag, ".err"},   int'(if_main.err),      0);
    check({tag, ".wrap8"}, int'(if_main.wrap_cnt), 0);
    check({tag, ".wrap_sat"},  int'(if_sat.wrap_cnt),  0);
    check({tag, ".wrap_roll"}, int'(if_roll.wrap_cnt), 0);
  endtask

  // Assert reset between clock edges, check it took effect at once, and
  // release it just after a rising edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset(tag);
    $display("txn %s async reset", tag);
    exp_pm    = 1'b0;
    exp_wraps = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    exp_pm    = 1'b0;
    exp_wraps = 0;
    rst       = 1'b1;
    c_in_tb   = 4'd0;
    load_tb   = 1'b0;
    clr_tb    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // T1: count 0,1..11,0.
    drive("t1_init", 4'd0, 1'b0, 1'b0, 12, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++)
      drive("t1_step", 4'(i), 1'b0, 1'b0, i, 1'b1, 1'b0);
    exp_pm = 1'b1; exp_wraps = 1;
    drive("t1_wrap", 4'd0, 1'b0, 1'b0, 12, 1'b1, 1'b0);
    drive("t1_hold", 4'd0, 1'b0, 1'b0, 12, 1'b0, 1'b0);

    // T2: load from 3 to 5.
    for (int i = 1; i <= 3; i++)
      drive("t2_step", 4'(i), 1'b0, 1'b0, i, 1'b1, 1'b0);
    drive("t2_load", 4'd3, 1'b1, 1'b0, 3, 1'b0, 1'b0);
    drive("t2_jump", 4'd5, 1'b0, 1'b0, 5, 1'b1, 1'b0);

    // T3: illegal count, fault hold, recovery, then clear.
    drive("t3_bad",     4'd13, 1'b0, 1'b0, 5,  1'b0, 1'b1);
    drive("t3_fault",   4'd15, 1'b0, 1'b0, 5,  1'b0, 1'b1);
    drive("t3_recover", 4'd0,  1'b0, 1'b0, 12, 1'b1, 1'b1);
    drive("t3_clr",     4'd0,  1'b0, 1'b1, 12, 1'b0, 1'b0);

    // T4: a skip with no load raises err, even with err_clr in the same cycle.
    drive("t4_step", 4'd1, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    drive("t4_step", 4'd2, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    drive("t4_skip", 4'd7, 1'b0, 1'b1, 7, 1'b1, 1'b1);
    drive("t4_clr",  4'd7, 1'b0, 1'b1, 7, 1'b0, 1'b0);
    for (int i = 8; i <= 11; i++)
      drive("t4_step", 4'(i), 1'b0, 1'b0, i, 1'b1, 1'b0);
    // A load from 11 to 0 is still a wrap.
    drive("t4_ldhold", 4'd11, 1'b1, 1'b0, 11, 1'b0, 1'b0);
    exp_pm = 1'b0; exp_wraps = 2;
    drive("t4_ldwrap", 4'd0, 1'b0, 1'b0, 12, 1'b1, 1'b0);

    // T6: asynchronous reset mid-count. The first sample after release is 6.
    drive("t6_step", 4'd1, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    drive("t6_step", 4'd2, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    drive("t6_step", 4'd3, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    async_reset("t6_rst");
    drive("t6_init", 4'd6, 1'b0, 1'b0, 6, 1'b1, 1'b0);

    // T5: five wraps from reset. Saturating 2-bit ends at 3, rolling at 1.
    for (int i = 7; i <= 11; i++)
      drive("t5_step", 4'(i), 1'b0, 1'b0, i, 1'b1, 1'b0);
    exp_pm = ~exp_pm; exp_wraps++;
    drive("t5_wrap", 4'd0, 1'b0, 1'b0, 12, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 4; cyc++) begin
      for (int i = 1; i <= 11; i++)
        drive("t5_step", 4'(i), 1'b0, 1'b0, i, 1'b1, 1'b0);
      exp_pm = ~exp_pm; exp_wraps++;
      drive("t5_wrap", 4'd0, 1'b0, 1'b0, 12, 1'b1, 1'b0);
    end

    // Illegal count on the first edge after reset, then recovery.
    async_reset("t7_rst");
    drive("t7_init_bad", 4'd14, 1'b0, 1'b0, 12, 1'b0, 1'b1);
    drive("t7_recover",  4'd3,  1'b0, 1'b0, 3,  1'b1, 1'b1);
    drive("t7_step",     4'd4,  1'b0, 1'b1, 4,  1'b1, 1'b0);

    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
